// File: rtl/fifo_rd_streamer.sv
// Pops a 1-cycle-latency synchronous FIFO into a valid/ready stream through a 2-entry skid buffer.
// First byte appears 2 cycles after fifo_rd_en; reads stop the same cycle the buffer cannot absorb one more byte.
module fifo_rd_streamer #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              fifo_empty,
   output logic              fifo_rd_en,
   input  logic [DATA_W-1:0] fifo_rd_data,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   input  logic              m_ready,
   output logic [CNT_W-1:0]  pop_count,
   output logic              busy
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_t;

   occ_t              occ_q, occ_d;
   logic              inflight_q;
   logic [DATA_W-1:0] head_q, head_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              xfer;
   logic              room;

   assign m_valid   = (occ_q != EMPTY);
   assign m_data    = head_q;
   assign pop_count = cnt_q;
   assign busy      = (occ_q != EMPTY) || inflight_q;
   assign xfer      = m_valid && m_ready;

   // Room means occupancy plus the byte already in flight stays below two.
   assign room       = (occ_q == EMPTY) || ((occ_q == ONE) && !inflight_q);
   assign fifo_rd_en = rst_n && ena && !fifo_empty && (room || xfer);

   always_comb begin
      occ_d  = occ_q;
      head_d = head_q;
      skid_d = skid_q;
      cnt_d  = cnt_q;

      if (xfer) begin
         cnt_d = cnt_q + 1'b1;
      end

      if (xfer && (occ_q == TWO)) begin
         head_d = skid_q;
      end

      // A stalled head must not change, so arrivals then land in the skid entry.
      if (inflight_q) begin
         if ((occ_q == EMPTY) || ((occ_q == ONE) && xfer)) begin
            head_d = fifo_rd_data;
         end else begin
            skid_d = fifo_rd_data;
         end
      end

      case (occ_q)
         EMPTY: begin
            if (inflight_q) occ_d = ONE;
         end
         ONE: begin
            if (inflight_q && !xfer)      occ_d = TWO;
            else if (!inflight_q && xfer) occ_d = EMPTY;
         end
         TWO: begin
            if (xfer && !inflight_q) occ_d = ONE;
         end
         default: occ_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q      <= EMPTY;
         inflight_q <= 1'b0;
         head_q     <= '0;
         skid_q     <= '0;
         cnt_q      <= '0;
      end else begin
         occ_q      <= occ_d;
         inflight_q <= fifo_rd_en;
         head_q     <= head_d;
         skid_q     <= skid_d;
         cnt_q      <= cnt_d;
      end
   end

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Bench for fifo_rd_streamer: cycle vectors for the single-byte/backpressure timeline, plus FIFO-model sequences.
module tb_fifo_rd_streamer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b1;
   logic       m_ready = 1'b1;
   logic       use_model = 1'b0;
   logic       vec_empty = 1'b0;
   logic [7:0] vec_rd_data = 8'h00;
   logic [7:0] mod_rd_data = 8'h00;
   logic       fifo_empty;
   logic [7:0] fifo_rd_data;
   logic       fifo_rd_en, m_valid, busy;
   logic [7:0] m_data, pop_count;
   logic       w4_rd_en, w4_valid, w4_busy;
   logic [7:0] w4_data;
   logic [3:0] w4_count;

   logic [7:0] fdata [0:255];
   int         pushed_n = 0;
   int         popped_n = 0;
   int         n_cmp = 0;
   int         n_err = 0;

   always #5 clk = ~clk;

   assign fifo_empty   = use_model ? (pushed_n == popped_n) : vec_empty;
   assign fifo_rd_data = use_model ? mod_rd_data : vec_rd_data;

   always @(posedge clk) begin
      if (use_model && fifo_rd_en) begin
         mod_rd_data <= fdata[popped_n[7:0]];
         popped_n    <= popped_n + 1;
      end
   end

   fifo_rd_streamer #(.DATA_W(8), .CNT_W(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .fifo_empty(fifo_empty),
      .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
      .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
      .pop_count(pop_count), .busy(busy)
   );

   fifo_rd_streamer #(.DATA_W(8), .CNT_W(4)) u_w4 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .fifo_empty(fifo_empty),
      .fifo_rd_en(w4_rd_en), .fifo_rd_data(fifo_rd_data),
      .m_valid(w4_valid), .m_data(w4_data), .m_ready(m_ready),
      .pop_count(w4_count), .busy(w4_busy)
   );

   typedef struct {
      logic       ena;
      logic       empty;
      logic       rdy;
      logic [7:0] rdat;
      logic       rd_en;
      logic       vld;
      logic [7:0] dat;
      logic [7:0] cnt;
      logic       bsy;
   } vec_t;

   vec_t vt [16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic push_seq(input logic [7:0] first, input int n);
      for (int i = 0; i < n; i++) begin
         fdata[pushed_n[7:0]] = first + 8'(i);
         pushed_n++;
      end
   endtask

   // mode 0: ready held high, no bubbles allowed; 1: ready pattern 1,0,0,1; 2: ready high, bubbles allowed.
   // Starts and ends at a falling edge; ena is low for 5 cycles from gap_at when gap_at >= 0.
   task automatic drain(input int n, input int mode, input int gap_at, input int budget);
      int         got = 0, cyc = 0, gaps = 0, idx;
      int         occ_b = 0, infl_b = 0;
      logic       started = 1'b0, prev_stall = 1'b0, x;
      logic [7:0] prev_data = 8'h00;
      idx = popped_n;
      while (got < n && cyc < budget) begin
         m_ready = (mode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
         ena     = !(gap_at >= 0 && cyc >= gap_at && cyc < gap_at + 5);
         #1;
         chk("valid_vs_occ", m_valid, occ_b != 0);
         chk("occ_le_2", occ_b <= 2, 1);
         if (prev_stall && m_valid) chk("stall_stable", m_data, prev_data);
         if (!ena) chk("ena_gap_no_read", fifo_rd_en, 0);
         if (fifo_empty) chk("no_empty_read", fifo_rd_en, 0);
         if (!m_ready && (occ_b + infl_b >= 2)) chk("bp_full_no_read", fifo_rd_en, 0);
         x = m_valid && m_ready;
         if (x) begin
            chk("order", m_data, fdata[idx[7:0]]);
            idx++;
            got++;
            started = 1'b1;
         end else if (mode == 0 && started) begin
            gaps++;
         end
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
         occ_b      = occ_b + infl_b - int'(x);
         infl_b     = int'(fifo_rd_en);
         cyc++;
         @(negedge clk);
      end
      chk("xfer_count", got, n);
      if (mode == 0) chk("stream_gaps", gaps, 0);
   endtask

   initial begin
      int   c;
      logic got0;

      vt[0]  = '{1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'd0, 1'b0};
      vt[1]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 8'd0, 1'b0};
      vt[2]  = '{1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 8'd0, 1'b1};
      vt[3]  = '{1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 8'hA5, 8'd0, 1'b1};
      vt[4]  = '{1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'd1, 1'b0};
      vt[5]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'd1, 1'b0};
      vt[6]  = '{1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 8'h00, 8'd1, 1'b1};
      vt[7]  = '{1'b1, 1'b0, 1'b0, 8'h22, 1'b0, 1'b1, 8'h11, 8'd1, 1'b1};
      vt[8]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 8'd1, 1'b1};
      vt[9]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'h11, 8'd1, 1'b1};
      vt[10] = '{1'b1, 1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 8'h22, 8'd2, 1'b1};
      vt[11] = '{1'b1, 1'b1, 1'b1, 8'h44, 1'b0, 1'b1, 8'h33, 8'd3, 1'b1};
      vt[12] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h44, 8'd4, 1'b1};
      vt[13] = '{1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 8'h44, 8'd4, 1'b1};
      vt[14] = '{1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'd5, 1'b0};
      vt[15] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'd5, 1'b0};

      // Reset held with a non-empty FIFO and reads enabled.
      #3;
      chk("rst_rd_en", fifo_rd_en, 0);
      chk("rst_valid", m_valid, 0);
      chk("rst_data", m_data, 0);
      chk("rst_count", pop_count, 0);
      chk("rst_busy", busy, 0);

      vec_empty = 1'b1;
      apply_reset();
      for (int i = 0; i < 16; i++) begin
         ena         = vt[i].ena;
         vec_empty   = vt[i].empty;
         m_ready     = vt[i].rdy;
         vec_rd_data = vt[i].rdat;
         #1;
         chk($sformatf("vec%0d_rd_en", i), fifo_rd_en, vt[i].rd_en);
         chk($sformatf("vec%0d_valid", i), m_valid, vt[i].vld);
         if (vt[i].vld) chk($sformatf("vec%0d_data", i), m_data, vt[i].dat);
         chk($sformatf("vec%0d_count", i), pop_count, vt[i].cnt);
         chk($sformatf("vec%0d_busy", i), busy, vt[i].bsy);
         @(negedge clk);
      end

      // Streaming 0x01..0x10 with ready held high.
      use_model = 1'b1;
      ena = 1'b1;
      m_ready = 1'b1;
      apply_reset();
      push_seq(8'h01, 16);
      drain(16, 0, -1, 200);
      #1;
      chk("stream_count", pop_count, 16);

      // Backpressure with ready toggling 1,0,0,1.
      apply_reset();
      push_seq(8'h01, 16);
      drain(16, 1, -1, 400);
      #1;
      chk("bp_count", pop_count, 16);

      // ena gap mid-stream and 4-bit counter wrap.
      apply_reset();
      push_seq(8'h60, 20);
      drain(20, 2, 6, 400);
      #1;
      chk("ena_count8", pop_count, 20);
      chk("wrap_count4", w4_count, 4);

      // Reset while both buffer entries are full.
      apply_reset();
      push_seq(8'h40, 8);
      ena = 1'b1;
      m_ready = 1'b1;
      got0 = 1'b0;
      c = 0;
      while (!got0 && c < 10) begin
         #1;
         if (m_valid) begin
            chk("mid_first_byte", m_data, 8'h40);
            got0 = 1'b1;
         end
         @(negedge clk);
         c++;
      end
      chk("mid_first_seen", got0, 1);
      m_ready = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      chk("mid_pre_valid", m_valid, 1);
      chk("mid_pre_head", m_data, 8'h41);
      chk("mid_pre_count", pop_count, 1);
      chk("mid_pre_full_no_read", fifo_rd_en, 0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", m_valid, 0);
      chk("mid_rst_count", pop_count, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_rd_en", fifo_rd_en, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      m_ready = 1'b1;
      chk("mid_left_in_fifo", pushed_n - popped_n > 0, 1);
      drain(pushed_n - popped_n, 0, -1, 100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
